// File: rtl/pulse_edge_scheduler.sv
// Pulse-train scheduler: after a start it emits cfg_count pulses as one-cycle rising/falling
// edge strobes with a programmable delay, width and period. Every output is a flop.
module pulse_edge_scheduler #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic             pulse_active,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NUM_W-1:0] pulse_idx
);

    typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] width_q, period_q;
    logic [NUM_W-1:0] count_q, idx_nxt, idx_inc;
    logic             latch, cfg_ok;
    logic             rise_nxt, fall_nxt, done_nxt, err_nxt;

    assign cfg_ok  = (cfg_count != '0) && (cfg_width != '0) && (cfg_period > cfg_width);
    assign idx_inc = (pulse_idx == count_q) ? pulse_idx : pulse_idx + NUM_W'(1);

    // cnt counts down the remaining delay in DELAY; in HIGH/LOW it is the
    // number of cycles since the last rising edge, so it never exceeds period-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = pulse_idx;
        latch     = 1'b0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (!cfg_ok) begin
                        err_nxt = 1'b1;
                    end else begin
                        latch = 1'b1;
                        if (cfg_delay == '0) begin
                            state_nxt = HIGH;
                            rise_nxt  = 1'b1;
                            idx_nxt   = NUM_W'(1);
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = DELAY;
                            idx_nxt   = '0;
                            cnt_nxt   = cfg_delay;
                        end
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = HIGH;
                    rise_nxt  = 1'b1;
                    idx_nxt   = idx_inc;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                // An abort closes the open pulse; a coincident scheduled fall merges into it.
                if (abort) begin
                    state_nxt = IDLE;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == width_q - CNT_W'(1)) begin
                        fall_nxt  = 1'b1;
                        state_nxt = (pulse_idx == count_q) ? FIN : LOW;
                    end
                end
            end
            LOW: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == period_q - CNT_W'(1)) begin
                    state_nxt = HIGH;
                    rise_nxt  = 1'b1;
                    idx_nxt   = idx_inc;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FIN: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            width_q      <= '0;
            period_q     <= '0;
            count_q      <= '0;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            pulse_active <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            pulse_idx    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rising_edge  <= rise_nxt;
            falling_edge <= fall_nxt;
            pulse_active <= (state_nxt == HIGH);
            busy         <= (state_nxt != IDLE);
            done         <= done_nxt;
            cfg_err      <= err_nxt;
            pulse_idx    <= idx_nxt;
            if (latch) begin
                width_q  <= cfg_width;
                period_q <= cfg_period;
                count_q  <= cfg_count;
            end
        end
    end

endmodule

// File: tb/tb_pulse_edge_scheduler.sv
// Randomized scoreboard bench for pulse_edge_scheduler; expected strobes come from an arithmetic
// train model, and a negedge monitor checks them together with busy/pulse_active every cycle.
module tb_pulse_edge_scheduler;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;
    localparam int MAXC  = 8192;
    localparam int K_RISE = 0, K_FALL = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] cfg_delay = '0, cfg_width = '0, cfg_period = '0;
    logic [NUM_W-1:0] cfg_count = '0;
    logic             rising_edge, falling_edge, pulse_active, busy, done, cfg_err;
    logic [NUM_W-1:0] pulse_idx;

    int  cyc = 0;
    int  tests = 0, fails = 0;
    int  last_idx = 0;
    bit  exp_busy [MAXC];
    bit  exp_act  [MAXC];
    ev_t sb[$];

    pulse_edge_scheduler #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .rising_edge(rising_edge), .falling_edge(falling_edge),
        .pulse_active(pulse_active), .busy(busy), .done(done), .cfg_err(cfg_err),
        .pulse_idx(pulse_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_chk(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe at cycle %0d: got kind %0d, expected none", cyc, kind);
            return;
        end
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        if (kind == K_RISE) check("rise_pulse_idx", pulse_idx, e.idx);
    endtask

    always @(negedge clk) begin
        if (!rst && cyc < MAXC) begin
            if (rising_edge)  pop_chk(K_RISE);
            if (falling_edge) pop_chk(K_FALL);
            if (done)         pop_chk(K_DONE);
            if (cfg_err)      pop_chk(K_ERR);
            check("busy", busy, exp_busy[cyc]);
            check("pulse_active", pulse_active, exp_act[cyc]);
        end
    end

    // Train seen as arithmetic: rise k at T+d+1+k*p, fall at rise+w, done after the
    // last fall. An abort at A before the last fall truncates everything after A;
    // if A lies inside a high window the pulse is closed at A+1.
    task automatic model_train(input int t, input int d, input int w, input int p,
                               input int n, input int a, output int endc);
        int  r, f, flast;
        bit  cut;
        flast = t + d + 1 + (n - 1) * p + w;
        cut   = (a >= 0) && (a < flast);
        endc  = cut ? a + 1 : flast + 1;
        last_idx = 0;
        for (int k = 0; k < n; k++) begin
            r = t + d + 1 + k * p;
            f = r + w;
            if (r < endc) begin
                sb.push_back('{K_RISE, r, k + 1});
                last_idx = k + 1;
                for (int c = r; c < f && c < endc && c < MAXC; c++) exp_act[c] = 1'b1;
            end
            if (f < endc) sb.push_back('{K_FALL, f, 0});
            else if (cut && r <= a && a < f) sb.push_back('{K_FALL, a + 1, 0});
        end
        for (int c = t + 1; c < endc && c < MAXC; c++) exp_busy[c] = 1'b1;
        if (!cut) sb.push_back('{K_DONE, flast + 1, 0});
    endtask

    task automatic scramble_cfg();
        cfg_delay  = CNT_W'($urandom_range(0, 65535));
        cfg_width  = CNT_W'($urandom_range(0, 65535));
        cfg_period = CNT_W'($urandom_range(0, 65535));
        cfg_count  = NUM_W'($urandom_range(0, 255));
    endtask

    // ab_off/st_off: cycles after the start at which abort / a stray start are
    // driven (0 = none). both=1 drives abort together with the start.
    task automatic run_train(input int d, input int w, input int p, input int n,
                             input int ab_off, input int st_off, input bit both);
        int  t, endc;
        bit  ok;
        @(posedge clk); #1;
        t = cyc;
        cfg_delay = CNT_W'(d); cfg_width = CNT_W'(w);
        cfg_period = CNT_W'(p); cfg_count = NUM_W'(n);
        start = 1'b1;
        abort = both;
        ok = (n != 0) && (w != 0) && (p > w);
        if (both) begin
            endc = t + 1;
        end else if (!ok) begin
            sb.push_back('{K_ERR, t + 1, 0});
            endc = t + 1;
        end else begin
            model_train(t, d, w, p, n, (ab_off > 0) ? t + ab_off : -1, endc);
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        while (cyc < endc + 2) begin
            if (ab_off > 0 && cyc == t + ab_off) abort = 1'b1;
            if (st_off > 0 && cyc == t + st_off && cyc < endc) start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            scramble_cfg();
        end
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
        check("final_pulse_idx", pulse_idx, last_idx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rising"}, rising_edge, 0);
        check({tag, "_falling"}, falling_edge, 0);
        check({tag, "_active"}, pulse_active, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_pulse_idx"}, pulse_idx, 0);
    endtask

    task automatic reset_mid_train();
        int t, endc;
        @(posedge clk); #1;
        t = cyc;
        cfg_delay = 2; cfg_width = 3; cfg_period = 5; cfg_count = 3;
        start = 1'b1;
        model_train(t, 2, 3, 5, 3, -1, endc);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 4) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1 check_all_zero("midtrain_reset");
        sb.delete();
        for (int c = cyc; c < MAXC; c++) begin
            exp_busy[c] = 1'b0;
            exp_act[c]  = 1'b0;
        end
        last_idx = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int d, w, p, n, ab, st, sel;
        #1 check_all_zero("reset_state");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        run_train(2, 3, 5, 3, 0, 0, 0);    // nominal three-pulse train
        run_train(0, 1, 2, 1, 0, 0, 0);    // zero delay, minimal pulse
        run_train(0, 4, 4, 1, 0, 0, 0);    // period == width rejected
        run_train(1, 0, 4, 2, 0, 0, 0);    // zero width rejected
        run_train(1, 2, 4, 0, 0, 0, 0);    // zero count rejected
        run_train(2, 3, 5, 3, 9, 0, 0);    // abort while high
        run_train(2, 3, 5, 3, 5, 0, 0);    // abort on the cycle the fall is due
        run_train(2, 3, 5, 3, 2, 0, 0);    // abort in delay
        run_train(2, 3, 5, 3, 7, 0, 0);    // abort in low
        run_train(2, 3, 5, 3, 16, 0, 0);   // abort in the final falling cycle
        run_train(2, 3, 5, 3, 0, 5, 0);    // stray start mid-train
        run_train(2, 3, 5, 3, 0, 0, 1);    // abort and start together
        run_train(0, 1, 2, 255, 0, 0, 0);  // maximum pulse count
        reset_mid_train();
        run_train(2, 3, 5, 3, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 19);
            d = $urandom_range(0, 5);
            w = $urandom_range(1, 4);
            p = w + $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            ab = 0;
            st = 0;
            if (sel < 2) begin
                case ($urandom_range(0, 2))
                    0: n = 0;
                    1: w = 0;
                    default: p = $urandom_range(1, w);
                endcase
                run_train(d, w, p, n, 0, 0, 0);
            end else if (sel == 2) begin
                run_train(d, w, p, n, 0, 0, 1);
            end else begin
                if ($urandom_range(0, 1) == 1) ab = $urandom_range(1, d + 2 + (n - 1) * p + w);
                if ($urandom_range(0, 2) == 0) st = $urandom_range(1, 20);
                run_train(d, w, p, n, ab, st, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
